gearbox: RTL and testbench



---
 rtl/gearbox_pkg.sv | 32 +++
 rtl/gearbox_shift_light_ctl.sv | 47 ++++
 rtl/gearbox.sv | 92 +++++++++
 tb/tb_gearbox.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gearbox_pkg.sv
// Shared game constants: rpm thresholds and upshift grade encoding reused by HUD/scoring.
package gearbox_pkg;

    localparam logic [13:0] GOOD_LO      = 14'd5000;
    localparam logic [13:0] PERFECT_LO   = 14'd7000;
    localparam logic [13:0] PERFECT_HI   = 14'd9000;
    localparam logic [13:0] DOWN_MAX_RPM = 14'd6000;

    typedef enum logic [1:0] {
        GRADE_EARLY   = 2'd0,
        GRADE_GOOD    = 2'd1,
        GRADE_PERFECT = 2'd2,
        GRADE_LATE    = 2'd3
    } grade_t;

    typedef enum logic {
        IDLE     = 1'b0,
        SHIFTING = 1'b1
    } state_t;

    function automatic grade_t grade_of(input logic [13:0] r);
        if (r < GOOD_LO)
            return GRADE_EARLY;
        else if (r < PERFECT_LO)
            return GRADE_GOOD;
        else if (r <= PERFECT_HI)
            return GRADE_PERFECT;
        else
            return GRADE_LATE;
    endfunction

endpackage

// File: rtl/gearbox_shift_light_ctl.sv
// Cockpit shift light: steady in the perfect band, blinking above it, dark in top gear.
module gearbox_shift_light_ctl
    import gearbox_pkg::*;
#(
    parameter int BLINK_HALF = 10
) (
    input  logic        clk100Hz,
    input  logic        rst,
    input  logic [13:0] rpm,
    input  logic [1:0]  gear,
    output logic        shift_light
);

    localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [CW-1:0] blink_cnt;
    logic          blink_phase;
    logic          top_gear;
    logic          in_blink;
    logic          in_steady;

    assign top_gear  = (gear == 2'd3);
    assign in_blink  = !top_gear && (rpm > PERFECT_HI);
    assign in_steady = !top_gear && (rpm >= PERFECT_LO) && (rpm <= PERFECT_HI);

    // Light follows the phase held before this edge, so band entry lights it at once.
    always_ff @(posedge clk100Hz) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            shift_light <= 1'b0;
        end else if (in_blink) begin
            shift_light <= blink_phase;
            if (blink_cnt == CW'(BLINK_HALF - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end else begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            shift_light <= in_steady;
        end
    end

endmodule

// File: rtl/gearbox.sv
// Player gear selector: key edges -> gear command with post-shift lockout and upshift grading.
module gearbox
    import gearbox_pkg::*;
#(
    parameter int SHIFT_LOCK = 25,
    parameter int BLINK_HALF = 10
) (
    input  logic        clk100Hz,
    input  logic        rst,
    input  logic        reset_status,
    input  logic        shift_up_key,
    input  logic        shift_down_key,
    input  logic [13:0] rpm,
    output logic [1:0]  gear,
    output logic        shifting,
    output logic        shift_light,
    output logic [1:0]  grade,
    output logic        grade_valid
);

    localparam int LW = $clog2(SHIFT_LOCK + 1);

    logic          sync_rst;
    logic          up_prev;
    logic          down_prev;
    logic          up_edge;
    logic          down_edge;
    state_t        state;
    logic [LW-1:0] lock;

    assign sync_rst  = rst | reset_status;
    assign up_edge   = shift_up_key & ~up_prev;
    assign down_edge = shift_down_key & ~down_prev;

    // grade_valid is a one-cycle pulse with no back-pressure: grade is new exactly when it is high.
    always_ff @(posedge clk100Hz) begin
        if (sync_rst) begin
            up_prev     <= 1'b0;
            down_prev   <= 1'b0;
            state       <= IDLE;
            lock        <= '0;
            gear        <= 2'd0;
            shifting    <= 1'b0;
            grade       <= GRADE_EARLY;
            grade_valid <= 1'b0;
        end else begin
            up_prev     <= shift_up_key;
            down_prev   <= shift_down_key;
            grade_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (up_edge && !down_edge && gear != 2'd3) begin
                        gear        <= gear + 2'd1;
                        lock        <= LW'(SHIFT_LOCK - 1);
                        state       <= SHIFTING;
                        shifting    <= 1'b1;
                        grade       <= grade_of(rpm);
                        grade_valid <= 1'b1;
                    end else if (down_edge && !up_edge && gear != 2'd0 && rpm <= DOWN_MAX_RPM) begin
                        gear     <= gear - 2'd1;
                        lock     <= LW'(SHIFT_LOCK - 1);
                        state    <= SHIFTING;
                        shifting <= 1'b1;
                    end
                end
                SHIFTING: begin
                    if (lock == '0) begin
                        state    <= IDLE;
                        shifting <= 1'b0;
                    end else begin
                        lock <= lock - 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    shifting <= 1'b0;
                end
            endcase
        end
    end

    gearbox_shift_light_ctl #(
        .BLINK_HALF (BLINK_HALF)
    ) u_shift_light_ctl (
        .clk100Hz    (clk100Hz),
        .rst         (sync_rst),
        .rpm         (rpm),
        .gear        (gear),
        .shift_light (shift_light)
    );

endmodule

// File: tb/tb_gearbox.sv
// Gearbox bench: directed scenarios plus random keys/rpm against a cycle-count reference model.
module tb_gearbox;

    logic        clk100Hz = 1'b0;
    logic        rst = 1'b1;
    logic        reset_status = 1'b0;
    logic        shift_up_key = 1'b0;
    logic        shift_down_key = 1'b0;
    logic [13:0] rpm = 14'd0;
    logic [1:0]  gear;
    logic        shifting;
    logic        shift_light;
    logic [1:0]  grade;
    logic        grade_valid;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int cyc = 0;
    int last_acc = -1000;
    int band_start = 0;
    bit in_band = 0;
    bit m_up_prev = 0;
    bit m_dn_prev = 0;
    int m_gear = 0;
    int m_grade = 0;
    bit m_gv = 0;
    bit m_shifting = 0;
    bit m_light = 0;

    gearbox dut (
        .clk100Hz       (clk100Hz),
        .rst            (rst),
        .reset_status   (reset_status),
        .shift_up_key   (shift_up_key),
        .shift_down_key (shift_down_key),
        .rpm            (rpm),
        .gear           (gear),
        .shifting       (shifting),
        .shift_light    (shift_light),
        .grade          (grade),
        .grade_valid    (grade_valid)
    );

    always #5 clk100Hz = ~clk100Hz;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int grade_band(input int r);
        if (r < 5000) return 0;
        if (r < 7000) return 1;
        if (r <= 9000) return 2;
        return 3;
    endfunction

    // One clock edge: advance the model on the inputs seen at that edge.
    task automatic model_edge();
        bit up_e;
        bit dn_e;
        int r;
        r = int'(rpm);
        cyc++;
        if (rst || reset_status) begin
            m_gear = 0; m_grade = 0; m_gv = 0; m_light = 0;
            m_up_prev = 0; m_dn_prev = 0;
            in_band = 0; last_acc = -1000;
        end else begin
            up_e = shift_up_key && !m_up_prev;
            dn_e = shift_down_key && !m_dn_prev;
            if (m_gear != 3 && r > 9000) begin
                if (!in_band) band_start = cyc;
                in_band = 1;
                m_light = (((cyc - band_start) / 10) % 2) == 0;
            end else begin
                in_band = 0;
                m_light = (m_gear != 3) && r >= 7000;
            end
            m_gv = 0;
            // 25 cycles of lockout follow an accepted shift, then one cycle returning to idle
            if (cyc - last_acc >= 26) begin
                if (up_e && !dn_e && m_gear < 3) begin
                    m_gear++;
                    m_grade = grade_band(r);
                    m_gv = 1;
                    last_acc = cyc;
                end else if (dn_e && !up_e && m_gear > 0 && r <= 6000) begin
                    m_gear--;
                    last_acc = cyc;
                end
            end
            m_up_prev = shift_up_key;
            m_dn_prev = shift_down_key;
        end
        m_shifting = (cyc - last_acc) <= 24;
    endtask

    task automatic step();
        @(posedge clk100Hz);
        model_edge();
        #1;
        check("gear", int'(gear), m_gear);
        check("shifting", int'(shifting), int'(m_shifting));
        check("shift_light", int'(shift_light), int'(m_light));
        check("grade", int'(grade), m_grade);
        check("grade_valid", int'(grade_valid), int'(m_gv));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_up();
        shift_up_key = 1'b1;
        step();
        shift_up_key = 1'b0;
    endtask

    task automatic pulse_dn();
        shift_down_key = 1'b1;
        step();
        shift_down_key = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        step();
    endtask

    initial begin
        int cnt;
        int walk;

        do_reset();
        check("reset_gear", int'(gear), 0);
        check("reset_light", int'(shift_light), 0);

        // first upshift, early grade, lockout length
        rpm = 14'd1140;
        pulse_up();
        check("up1_gear", int'(gear), 1);
        check("up1_grade", int'(grade), 0);
        check("up1_gv", int'(grade_valid), 1);
        cnt = int'(shifting);
        for (int i = 0; i < 30; i++) begin
            step();
            cnt += int'(shifting);
        end
        check("lock_len", cnt, 25);

        // perfect upshift, ignored press during lockout, next allowed press
        rpm = 14'd8000;
        pulse_up();
        check("up2_gear", int'(gear), 2);
        check("up2_grade", int'(grade), 2);
        idle(9);
        pulse_up();
        check("locked_gear", int'(gear), 2);
        idle(15);
        pulse_up();
        check("up3_gear", int'(gear), 3);
        idle(30);

        // top gear and downshift limits
        pulse_up();
        check("top_gear", int'(gear), 3);
        check("top_gv", int'(grade_valid), 0);
        idle(3);
        rpm = 14'd7000;
        pulse_dn();
        check("dn_overrev", int'(gear), 3);
        idle(3);
        rpm = 14'd6000;
        pulse_dn();
        check("dn_ok", int'(gear), 2);
        check("dn_grade", int'(grade), 2);
        idle(30);

        // simultaneous keys, then a long hold
        shift_up_key = 1'b1;
        shift_down_key = 1'b1;
        step();
        check("both_gear", int'(gear), 2);
        shift_up_key = 1'b0;
        shift_down_key = 1'b0;
        step();
        shift_up_key = 1'b1;
        idle(100);
        shift_up_key = 1'b0;
        check("hold_gear", int'(gear), 3);
        idle(5);

        // shift light ramp in gear 1, then dark in top gear
        do_reset();
        rpm = 14'd1000;
        pulse_up();
        idle(30);
        for (int r = 6990; r <= 9500; r += 10) begin
            rpm = 14'(r);
            step();
        end
        idle(40);
        pulse_up();
        idle(30);
        pulse_up();
        idle(10);
        check("top_light", int'(shift_light), 0);

        // race restart mid-lockout
        do_reset();
        rpm = 14'd3000;
        pulse_up();
        idle(30);
        pulse_up();
        idle(5);
        reset_status = 1'b1;
        step();
        reset_status = 1'b0;
        check("rs_gear", int'(gear), 0);
        check("rs_shifting", int'(shifting), 0);
        check("rs_grade", int'(grade), 0);
        pulse_up();
        check("rs_up_gear", int'(gear), 1);
        idle(30);

        // random keys with a wandering rpm
        walk = 5000;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0)
                walk = int'($urandom_range(0, 11000));
            else
                walk += int'($urandom_range(0, 400)) - 200;
            if (walk < 0) walk = 0;
            if (walk > 11000) walk = 11000;
            rpm = 14'(walk);
            shift_up_key = ($urandom_range(0, 9) < 2);
            shift_down_key = ($urandom_range(0, 9) < 2);
            reset_status = ($urandom_range(0, 299) == 0);
            rst = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0;
        reset_status = 1'b0;
        shift_up_key = 1'b0;
        shift_down_key = 1'b0;
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
